demux_1an_fifo: RTL and testbench
=================================

Name: demux_1an_fifo

Overview:
Parametrised 1-to-N demultiplexer with buffering. It steers a valid-qualified data word from one input stream into one of CHANNELS per-channel FIFOs. The target channel comes either from an explicit selector or from an internal round-robin pointer. Each output channel presents show-ahead valid/data and is drained independently by its own pop, which gives backpressure toward the input.

Parameters:
WIDTH, 8, data word width in bits
CHANNELS, 2, number of output channels (>=2)
DEPTH, 4, entries per channel FIFO (power of 2, >=2)
SEL_W, $clog2(CHANNELS), selector / round-robin pointer width (localparam)

Ports:
clk  input  1  rising-edge clock
reset_L  input  1  asynchronous active-low reset
valid_in  input  1  input word valid
data_in  input  WIDTH  input word
selector  input  SEL_W  target channel when mode_rr=0
mode_rr  input  1  1 = round-robin steering, 0 = selector steering
in_ready  output  1  target channel can accept this cycle (combinational)
pop  input  CHANNELS  per-channel read strobe
valid_out  output  CHANNELS  per-channel FIFO non-empty
data_out  output  CHANNELS*WIDTH  per-channel head word; channel i at [i*WIDTH +: WIDTH]
full  output  CHANNELS  per-channel FIFO full
sel_err  output  1  registered one-cycle pulse for out-of-range selector
drop_cnt  output  8  saturating count of out-of-range attempts

Behaviour:
- One clock; reset is asynchronous, active-low on reset_L.
- While reset_L=0, all of the following are held at 0:
  - per-channel rd/wr pointers, counts and storage
  - rr_ptr, valid_out, data_out, full, sel_err, drop_cnt
  - in_ready, which is forced 0.
- Reset asserted mid-operation discards all buffered words immediately.
- Target tgt = mode_rr ? rr_ptr : selector.
- tgt_ok = (tgt < CHANNELS).
- in_ready = reset_L & tgt_ok & ~full[tgt]. This is combinational from selector, mode_rr and the FIFO state.
- Push occurs when valid_in & in_ready: data_in is written to FIFO[tgt] at the rising edge.
- Latency: a pushed word drives valid_out[tgt]=1 and appears on the data_out slice one cycle after the accepting edge. There is no same-cycle bypass.
- Show-ahead output: valid_out[i] = (count[i]!=0), and data_out slice i = head entry of FIFO i.
- Pop on channel i occurs when pop[i] & valid_out[i]; the head advances at the edge.
  - pop on an empty channel is ignored, with no state change.
- Push and pop on the same non-full, non-empty channel in one cycle: count unchanged, both pointers advance.
- Full channel: in_ready=0 even if that channel is popped in the same cycle (no full-bypass). The push takes place the following cycle.
- Pops on different channels are independent and any number may occur in one cycle.
- Pointers wrap DEPTH-1 -> 0.
- full[i] = (count[i]==DEPTH). The count width is $clog2(DEPTH)+1.
- rr_ptr:
  - advances only on an accepted push while mode_rr=1, wrapping CHANNELS-1 -> 0
  - stalls on a full target; full channels are never skipped, so ordering is strict
  - holds its value when mode_rr=0, and resumes from that value when mode_rr returns to 1.
- Out-of-range selector (mode_rr=0, selector>=CHANNELS, only possible for non-power-of-2 CHANNELS) with valid_in=1:
  - no push
  - sel_err=1 for exactly the next cycle
  - drop_cnt increments, saturating at 255.
  - Held valid_in re-pulses sel_err every cycle.
- valid_in=0: no state change except pops.
- data_in is don't-care when valid_in=0.

Test Plan:
- Reset: assert reset_L=0 mid-stream with 3 words buffered in ch0 -> valid_out=0, data_out=0, in_ready=0, drop_cnt=0 asynchronously; after release ch0 is empty.
- Selector mode (CHANNELS=2, DEPTH=4): push 0xA1 sel=0, then 0xB2 sel=1 -> valid_out=2'b01 after the 1st edge and 2'b11 after the 2nd; data_out={0xB2,0xA1}; pop=2'b11 -> valid_out=2'b00.
- Full/backpressure: push 0x10..0x13 to ch1 with no pop -> full[1]=1, in_ready=0 with sel=1. Assert pop[1] and valid_in together -> no push that cycle, pushed next cycle. Drain order is 0x10,0x11,0x12,0x13,0x14.
- Round-robin: mode_rr=1, push 0x01..0x04 continuously -> ch0 holds 0x01,0x03 and ch1 holds 0x02,0x04. Fill ch0 so it is full while rr_ptr=0 -> in_ready stays 0 and ch1 receives nothing until ch0 is popped.
- Out-of-range (CHANNELS=3): valid_in=1, selector=3 for 2 cycles -> no valid_out change, sel_err high 2 cycles (one cycle lagged), drop_cnt=2; saturation check: 300 attempts -> drop_cnt=255.
- Simultaneous push/pop with wrap: ch0 holds 2 entries, push+pop every cycle for 10 cycles -> count stays 2, pointers wrap, and output order equals input order.

Source files
------------

// File: rtl/demux_1an_fifo.sv
// 1-to-N demultiplexer that steers a valid-qualified word into per-channel FIFOs.
// Channel choice is an explicit selector or a strict round-robin pointer.
module demux_1an_fifo #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 2,
    parameter  int DEPTH    = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      valid_in,
    input  logic [WIDTH-1:0]          data_in,
    input  logic [SEL_W-1:0]          selector,
    input  logic                      mode_rr,
    output logic                      in_ready,
    input  logic [CHANNELS-1:0]       pop,
    output logic [CHANNELS-1:0]       valid_out,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]       full,
    output logic                      sel_err,
    output logic [7:0]                drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);

    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]    tgt;
    logic                tgt_ok;
    logic                full_sel;
    logic                push_ok;
    logic [CHANNELS-1:0] push_en;
    logic [CHANNELS-1:0] pop_en;
    logic                sel_err_q, sel_err_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;

    assign tgt = mode_rr ? rr_ptr_q : selector;

    // With a power-of-2 channel count every selector value names a real channel.
    if (CHANNELS == (1 << SEL_W)) begin : g_pow2
        assign tgt_ok = 1'b1;
    end else begin : g_npow2
        assign tgt_ok = ({1'b0, tgt} < CH_LIM);
    end

    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        full_sel = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (tgt == SEL_W'(i)) full_sel = full[i];
        end
    end

    // Readiness looks only at the pre-pop state: a full channel never accepts in the cycle it is popped.
    assign in_ready = reset_L & tgt_ok & ~full_sel;
    assign push_ok  = valid_in & in_ready;

    always_comb begin
        push_en = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            push_en[i] = push_ok && (tgt == SEL_W'(i));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push_ok && mode_rr) begin
            rr_ptr_d = (rr_ptr_q == SEL_W'(CHANNELS-1)) ? '0 : rr_ptr_q + SEL_W'(1);
        end
    end

    // Round-robin targets are always in range, so only selector mode can error.
    always_comb begin
        sel_err_d  = valid_in & ~tgt_ok;
        drop_cnt_d = drop_cnt_q;
        if (sel_err_d && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rr_ptr_q   <= '0;
            sel_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            sel_err_q  <= sel_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign sel_err  = sel_err_q;
    assign drop_cnt = drop_cnt_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]    count_q, count_d;

        assign pop_en[i] = pop[i] & valid_out[i];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (push_en[i]) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_en[i])  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_en[i], pop_en[i]})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // NOTE: storage is cleared on reset so data_out reads zero while reset_L is low.
        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                if (push_en[i]) mem_q[wr_ptr_q] <= data_in;
            end
        end

        assign valid_out[i]                = (count_q != '0);
        assign full[i]                     = (count_q == CW'(DEPTH));
        assign data_out[i*WIDTH +: WIDTH]  = mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_demux_1an_fifo.sv
// Directed bench for demux_1an_fifo: a 2-channel instance checked against a queue
// scoreboard, and a 3-channel instance for out-of-range selector handling.
module tb_demux_1an_fifo;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    // 2-channel instance
    logic        v2, sel2, rr2, rdy2, serr2;
    logic [7:0]  d2, drop2;
    logic [1:0]  pop2, vo2, full2;
    logic [15:0] do2;

    // 3-channel instance
    logic        v3, rr3, rdy3, serr3;
    logic [7:0]  d3, drop3;
    logic [1:0]  sel3;
    logic [2:0]  pop3, vo3, full3;
    logic [23:0] do3;

    demux_1an_fifo #(.WIDTH(8), .CHANNELS(2), .DEPTH(DEPTH)) u_dut2 (
        .clk(clk), .reset_L(reset_L), .valid_in(v2), .data_in(d2), .selector(sel2),
        .mode_rr(rr2), .in_ready(rdy2), .pop(pop2), .valid_out(vo2), .data_out(do2),
        .full(full2), .sel_err(serr2), .drop_cnt(drop2)
    );

    demux_1an_fifo #(.WIDTH(8), .CHANNELS(3), .DEPTH(DEPTH)) u_dut3 (
        .clk(clk), .reset_L(reset_L), .valid_in(v3), .data_in(d3), .selector(sel3),
        .mode_rr(rr3), .in_ready(rdy3), .pop(pop3), .valid_out(vo3), .data_out(do3),
        .full(full3), .sel_err(serr3), .drop_cnt(drop3)
    );

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard for the 2-channel instance: expected contents per channel plus rr pointer.
    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    logic       m_rr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the 2-channel instance, checked against the scoreboard.
    task automatic cyc2(input logic v, input logic [7:0] d, input logic s,
                        input logic rr, input logic [1:0] p);
        logic tgt, exp_rdy;
        int   sz;
        v2 = v; d2 = d; sel2 = s; rr2 = rr; pop2 = p;
        #1;
        tgt     = rr ? m_rr : s;
        sz      = tgt ? mq1.size() : mq0.size();
        exp_rdy = (sz < DEPTH);
        chk("in_ready", 32'(rdy2), 32'(exp_rdy));
        @(posedge clk);
        if (p[0] && mq0.size() > 0) void'(mq0.pop_front());
        if (p[1] && mq1.size() > 0) void'(mq1.pop_front());
        if (v && exp_rdy) begin
            if (tgt) mq1.push_back(d);
            else     mq0.push_back(d);
            if (rr) m_rr = ~m_rr;
        end
        #1;
        chk("valid_out", 32'(vo2), 32'({mq1.size() != 0, mq0.size() != 0}));
        chk("full", 32'(full2), 32'({mq1.size() == DEPTH, mq0.size() == DEPTH}));
        if (mq0.size() > 0) chk("ch0_head", 32'(do2[7:0]), 32'(mq0[0]));
        if (mq1.size() > 0) chk("ch1_head", 32'(do2[15:8]), 32'(mq1[0]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_L = 1'b0;
        v2 = 0; d2 = 0; sel2 = 0; rr2 = 0; pop2 = 0;
        v3 = 0; d3 = 0; sel3 = 0; rr3 = 0; pop3 = 0;
        #3;
        chk("rst_valid_out", 32'(vo2), 32'd0);
        chk("rst_data_out", 32'(do2), 32'd0);
        chk("rst_full", 32'(full2), 32'd0);
        chk("rst_in_ready", 32'(rdy2), 32'd0);
        chk("rst_sel_err", 32'(serr2), 32'd0);
        chk("rst_drop3", 32'(drop3), 32'd0);
        @(posedge clk); #1;
        reset_L = 1'b1;

        // Out-of-range selector on the 3-channel instance.
        v3 = 1; sel3 = 2'd3; d3 = 8'hEE;
        #1 chk("oor_in_ready", 32'(rdy3), 32'd0);
        @(posedge clk); #1;
        chk("oor_sel_err_1", 32'(serr3), 32'd1);
        chk("oor_drop_1", 32'(drop3), 32'd1);
        chk("oor_valid_1", 32'(vo3), 32'd0);
        @(posedge clk); #1;
        chk("oor_sel_err_2", 32'(serr3), 32'd1);
        chk("oor_drop_2", 32'(drop3), 32'd2);
        v3 = 0;
        @(posedge clk); #1;
        chk("oor_sel_err_off", 32'(serr3), 32'd0);
        chk("oor_drop_hold", 32'(drop3), 32'd2);
        chk("oor_valid_none", 32'(vo3), 32'd0);
        v3 = 1;
        repeat (300) @(posedge clk);
        #1;
        chk("oor_drop_sat", 32'(drop3), 32'd255);
        chk("oor_sel_err_held", 32'(serr3), 32'd1);
        v3 = 1; sel3 = 2'd2; d3 = 8'h55;
        #1 chk("ch2_in_ready", 32'(rdy3), 32'd1);
        @(posedge clk); #1;
        v3 = 0;
        chk("ch2_valid", 32'(vo3), 32'b100);
        chk("ch2_data", 32'(do3[23:16]), 32'h55);
        chk("ch2_sel_err", 32'(serr3), 32'd0);
        chk("ch2_drop_hold", 32'(drop3), 32'd255);
        pop3 = 3'b100;
        @(posedge clk); #1;
        pop3 = 3'b000;
        chk("ch2_drained", 32'(vo3), 32'd0);

        // Mid-stream asynchronous reset with three words buffered in ch0.
        cyc2(1, 8'hC0, 0, 0, 2'b00);
        cyc2(1, 8'hC1, 0, 0, 2'b00);
        cyc2(1, 8'hC2, 0, 0, 2'b00);
        v2 = 0;
        #2 reset_L = 1'b0;
        #1;
        chk("mid_rst_valid_out", 32'(vo2), 32'd0);
        chk("mid_rst_data_out", 32'(do2), 32'd0);
        chk("mid_rst_in_ready", 32'(rdy2), 32'd0);
        chk("mid_rst_drop3", 32'(drop3), 32'd0);
        mq0.delete(); mq1.delete(); m_rr = 1'b0;
        @(posedge clk); #1;
        reset_L = 1'b1;
        #1;
        chk("post_rst_empty", 32'(vo2), 32'd0);

        // Selector steering.
        cyc2(1, 8'hA1, 0, 0, 2'b00);
        cyc2(1, 8'hB2, 1, 0, 2'b00);
        chk("sel_data_out", 32'(do2), 32'hB2A1);
        cyc2(0, 8'h00, 0, 0, 2'b11);

        // Fill ch1, then pop with valid held: no full-bypass, push lands next cycle.
        for (int i = 0; i < 4; i++) cyc2(1, 8'h10 + 8'(i), 1, 0, 2'b00);
        chk("ch1_full", 32'(full2[1]), 32'd1);
        cyc2(1, 8'h14, 1, 0, 2'b10);
        cyc2(1, 8'h14, 1, 0, 2'b00);
        for (int i = 0; i < 5; i++) cyc2(0, 8'h00, 1, 0, 2'b10);

        // Round-robin steering with a strict stall on a full target.
        for (int i = 1; i <= 4; i++) cyc2(1, 8'(i), 0, 1, 2'b00);
        chk("rr_ch0_head", 32'(do2[7:0]), 32'h01);
        chk("rr_ch1_head", 32'(do2[15:8]), 32'h02);
        for (int i = 5; i <= 8; i++) cyc2(1, 8'(i), 0, 1, 2'b00);
        cyc2(0, 8'h00, 0, 1, 2'b10);
        cyc2(0, 8'h00, 0, 1, 2'b10);
        cyc2(1, 8'h09, 0, 1, 2'b00);
        cyc2(1, 8'h09, 0, 1, 2'b00);
        chk("rr_stall_full", 32'(full2), 32'b01);
        cyc2(1, 8'h09, 0, 1, 2'b01);
        cyc2(1, 8'h09, 0, 1, 2'b00);
        cyc2(1, 8'h0A, 0, 1, 2'b01);
        cyc2(1, 8'h0B, 0, 1, 2'b00);
        for (int i = 0; i < 4; i++) cyc2(0, 8'h00, 0, 0, 2'b11);

        // Concurrent push and pop on ch0 across pointer wrap.
        cyc2(1, 8'h20, 0, 0, 2'b00);
        cyc2(1, 8'h21, 0, 0, 2'b00);
        for (int i = 0; i < 10; i++) cyc2(1, 8'h22 + 8'(i), 0, 0, 2'b01);
        cyc2(0, 8'h00, 0, 0, 2'b01);
        cyc2(0, 8'h00, 0, 0, 2'b01);

        // Round-robin resumes from the value held during selector mode.
        cyc2(1, 8'h30, 0, 1, 2'b00);
        chk("rr_resume_ch1", 32'(do2[15:8]), 32'h30);
        cyc2(0, 8'h00, 0, 0, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
